// File: rtl/sc_reg_general_if.sv
// ---------------------------------------------------------------------------
// sc_reg_general_if
//   Bus bundle for the general-purpose shift/load register.
//   Writer side (master) drives the clear, write handshake, shift control and
//   serial input; the register (slave) returns its contents, the write
//   acknowledge, the shift carry and the zero/lsb flags.
//
//   Signals
//     SC_RegGENERAL_clear_InLow       master->slave  active-low synchronous clear
//     SC_RegGENERAL_wrreq_In          master->slave  write request (held until ack)
//     SC_RegGENERAL_data_InBUS        master->slave  write data
//     SC_RegGENERAL_shiftselection_In master->slave  00/11 hold, 01 left, 10 right
//     SC_RegGENERAL_serial_In         master->slave  bit shifted into vacated slot
//     SC_RegGENERAL_data_OutBUS       slave->master  register contents
//     SC_RegGENERAL_wrack_Out         slave->master  one-cycle write acknowledge
//     SC_RegGENERAL_carry_Out         slave->master  last bit shifted out
//     SC_RegGENERAL_zero_Out          slave->master  register == 0
//     SC_RegGENERAL_lsb_Out           slave->master  register bit 0
// ---------------------------------------------------------------------------
interface sc_reg_general_if #(
  parameter int DATAWIDTH_BUS = 8
);
  logic                     SC_RegGENERAL_clear_InLow;
  logic                     SC_RegGENERAL_wrreq_In;
  logic [DATAWIDTH_BUS-1:0] SC_RegGENERAL_data_InBUS;
  logic [1:0]               SC_RegGENERAL_shiftselection_In;
  logic                     SC_RegGENERAL_serial_In;
  logic [DATAWIDTH_BUS-1:0] SC_RegGENERAL_data_OutBUS;
  logic                     SC_RegGENERAL_wrack_Out;
  logic                     SC_RegGENERAL_carry_Out;
  logic                     SC_RegGENERAL_zero_Out;
  logic                     SC_RegGENERAL_lsb_Out;

  modport master (
    output SC_RegGENERAL_clear_InLow,
    output SC_RegGENERAL_wrreq_In,
    output SC_RegGENERAL_data_InBUS,
    output SC_RegGENERAL_shiftselection_In,
    output SC_RegGENERAL_serial_In,
    input  SC_RegGENERAL_data_OutBUS,
    input  SC_RegGENERAL_wrack_Out,
    input  SC_RegGENERAL_carry_Out,
    input  SC_RegGENERAL_zero_Out,
    input  SC_RegGENERAL_lsb_Out
  );

  modport slave (
    input  SC_RegGENERAL_clear_InLow,
    input  SC_RegGENERAL_wrreq_In,
    input  SC_RegGENERAL_data_InBUS,
    input  SC_RegGENERAL_shiftselection_In,
    input  SC_RegGENERAL_serial_In,
    output SC_RegGENERAL_data_OutBUS,
    output SC_RegGENERAL_wrack_Out,
    output SC_RegGENERAL_carry_Out,
    output SC_RegGENERAL_zero_Out,
    output SC_RegGENERAL_lsb_Out
  );
endinterface

// File: rtl/sc_reg_general.sv
// ---------------------------------------------------------------------------
// sc_reg_general
//   General-purpose register with handshaked parallel load, left/right shift
//   with serial fill and carry-out, synchronous clear, and zero/lsb flags
//   (the lsb is the even/odd decision for a Collatz datapath).
//
//   Ports
//     SC_RegGENERAL_CLOCK_50      clock, all state changes on its rising edge
//     SC_RegGENERAL_RESET_InHigh  synchronous active-high reset
//     bus                         sc_reg_general_if.slave (see interface file)
//
//   Parameters
//     DATAWIDTH_BUS         register/bus width, 2..32
//     DATA_REGGENERAL_INIT  value loaded on reset and on clear
//
//   Per-cycle priority: reset > clear > write capture > shift > hold.
//   A write is captured only from IDLE; the data is visible after that edge
//   and the acknowledge follows one cycle later, for one cycle.
// ---------------------------------------------------------------------------
module sc_reg_general #(
  parameter int                       DATAWIDTH_BUS        = 8,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REGGENERAL_INIT = '0
) (
  input  logic               SC_RegGENERAL_CLOCK_50,
  input  logic               SC_RegGENERAL_RESET_InHigh,
  sc_reg_general_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    WAITLOW = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic [DATAWIDTH_BUS-1:0] reg_q, reg_next;
  logic                     carry_q, carry_next;
  logic                     wrack_q;
  logic                     clear_active;
  logic                     capture;

  // Clear blocks capture, so a write coinciding with clear stays pending in
  // IDLE and is taken in the first cycle after clear releases.
  assign clear_active = !bus.SC_RegGENERAL_clear_InLow;
  assign capture      = (state == IDLE) && bus.SC_RegGENERAL_wrreq_In && !clear_active;

  // Next-state and datapath.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    reg_next   = reg_q;
    carry_next = carry_q;

    unique case (state)
      IDLE:    if (capture) state_next = ACK;
      ACK:     state_next = WAITLOW;
      WAITLOW: if (!bus.SC_RegGENERAL_wrreq_In) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Clear leaves the FSM alone; it only overrides the datapath. A shift
    // request in the capture cycle is dropped, not deferred.
    if (clear_active) begin
      reg_next   = DATA_REGGENERAL_INIT;
      carry_next = 1'b0;
    end else if (capture) begin
      reg_next = bus.SC_RegGENERAL_data_InBUS;
    end else begin
      unique case (bus.SC_RegGENERAL_shiftselection_In)
        2'b01: begin
          reg_next   = {reg_q[DATAWIDTH_BUS-2:0], bus.SC_RegGENERAL_serial_In};
          carry_next = reg_q[DATAWIDTH_BUS-1];
        end
        2'b10: begin
          reg_next   = {bus.SC_RegGENERAL_serial_In, reg_q[DATAWIDTH_BUS-1:1]};
          carry_next = reg_q[0];
        end
        default: ;  // 00 and 11 hold
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge SC_RegGENERAL_CLOCK_50) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      state   <= IDLE;
      reg_q   <= DATA_REGGENERAL_INIT;
      carry_q <= 1'b0;
      wrack_q <= 1'b0;
    end else begin
      state   <= state_next;
      reg_q   <= reg_next;
      carry_q <= carry_next;
      // Registered so the ack lands one cycle after the captured data is
      // visible, and reset clears it at the same edge as the FSM.
      wrack_q <= (state == ACK);
    end
  end

  assign bus.SC_RegGENERAL_data_OutBUS = reg_q;
  assign bus.SC_RegGENERAL_wrack_Out   = wrack_q;
  assign bus.SC_RegGENERAL_carry_Out   = carry_q;
  assign bus.SC_RegGENERAL_zero_Out    = (reg_q == '0);
  assign bus.SC_RegGENERAL_lsb_Out     = reg_q[0];

endmodule

// File: tb/tb_sc_reg_general.sv
// ---------------------------------------------------------------------------
// tb_sc_reg_general
//   Self-checking bench for sc_reg_general (W=8, INIT=0). A cycle model
//   predicts the outputs after each rising edge; predictions are queued when
//   the inputs are driven and popped/compared on the following falling edge.
//   Directed scenarios add literal checks for the documented cases.
// ---------------------------------------------------------------------------
module tb_sc_reg_general;

  localparam int            W    = 8;
  localparam logic [W-1:0]  INIT = '0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         wrack;
    logic         carry;
    logic         zero;
    logic         lsb;
  } exp_t;

  logic clk;
  logic rst;

  sc_reg_general_if #(.DATAWIDTH_BUS(W)) bus ();

  sc_reg_general #(
    .DATAWIDTH_BUS        (W),
    .DATA_REGGENERAL_INIT (INIT)
  ) dut (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_RESET_InHigh (rst),
    .bus                        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // Reference model state: 0 idle, 1 ack, 2 wait-low.
  logic [W-1:0] m_reg   = INIT;
  logic         m_carry = 1'b0;
  logic         m_ack   = 1'b0;
  int           m_state = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_step();
    logic cap;
    if (rst) begin
      m_reg   = INIT;
      m_carry = 1'b0;
      m_ack   = 1'b0;
      m_state = 0;
    end else begin
      cap   = (m_state == 0) && bus.SC_RegGENERAL_wrreq_In && bus.SC_RegGENERAL_clear_InLow;
      m_ack = (m_state == 1);
      if (!bus.SC_RegGENERAL_clear_InLow) begin
        m_reg   = INIT;
        m_carry = 1'b0;
      end else if (cap) begin
        m_reg = bus.SC_RegGENERAL_data_InBUS;
      end else if (bus.SC_RegGENERAL_shiftselection_In == 2'b01) begin
        m_carry = m_reg[W-1];
        m_reg   = {m_reg[W-2:0], bus.SC_RegGENERAL_serial_In};
      end else if (bus.SC_RegGENERAL_shiftselection_In == 2'b10) begin
        m_carry = m_reg[0];
        m_reg   = {bus.SC_RegGENERAL_serial_In, m_reg[W-1:1]};
      end
      if (m_state == 0)      m_state = cap ? 1 : 0;
      else if (m_state == 1) m_state = 2;
      else                   m_state = bus.SC_RegGENERAL_wrreq_In ? 2 : 0;
    end
  endtask

  // One clock: predict, wait for the edge, compare on the falling edge.
  task automatic tick();
    exp_t e;
    model_step();
    e.data  = m_reg;
    e.wrack = m_ack;
    e.carry = m_carry;
    e.zero  = (m_reg == '0);
    e.lsb   = m_reg[0];
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'(e.data));
      check("sb_wrack", 32'(bus.SC_RegGENERAL_wrack_Out),   32'(e.wrack));
      check("sb_carry", 32'(bus.SC_RegGENERAL_carry_Out),   32'(e.carry));
      check("sb_zero",  32'(bus.SC_RegGENERAL_zero_Out),    32'(e.zero));
      check("sb_lsb",   32'(bus.SC_RegGENERAL_lsb_Out),     32'(e.lsb));
    end
  endtask

  // Full handshake: capture, ack, return to idle.
  task automatic write(input logic [W-1:0] value);
    bus.SC_RegGENERAL_wrreq_In   = 1'b1;
    bus.SC_RegGENERAL_data_InBUS = value;
    tick();
    bus.SC_RegGENERAL_wrreq_In = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [W-1:0] rnd_data;

    rst = 1'b1;
    bus.SC_RegGENERAL_clear_InLow       = 1'b1;
    bus.SC_RegGENERAL_wrreq_In          = 1'b0;
    bus.SC_RegGENERAL_data_InBUS        = '0;
    bus.SC_RegGENERAL_shiftselection_In = 2'b00;
    bus.SC_RegGENERAL_serial_In         = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h00);
    check("rst_zero",  32'(bus.SC_RegGENERAL_zero_Out),    32'd1);
    check("rst_lsb",   32'(bus.SC_RegGENERAL_lsb_Out),     32'd0);
    check("rst_carry", 32'(bus.SC_RegGENERAL_carry_Out),   32'd0);
    check("rst_wrack", 32'(bus.SC_RegGENERAL_wrack_Out),   32'd0);
    rst = 1'b0;
    tick();

    // Write 0x1B held for three cycles: one capture, ack only in cycle 2
    bus.SC_RegGENERAL_wrreq_In   = 1'b1;
    bus.SC_RegGENERAL_data_InBUS = 8'h1B;
    tick();
    check("wr_data_e1",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h1B);
    check("wr_ack_e1",   32'(bus.SC_RegGENERAL_wrack_Out),   32'd0);
    tick();
    check("wr_ack_e2",   32'(bus.SC_RegGENERAL_wrack_Out),   32'd1);
    tick();
    check("wr_ack_e3",   32'(bus.SC_RegGENERAL_wrack_Out),   32'd0);
    bus.SC_RegGENERAL_wrreq_In = 1'b0;
    tick();
    check("wr_ack_e4",   32'(bus.SC_RegGENERAL_wrack_Out),   32'd0);
    check("wr_data_e4",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h1B);

    // 0x81: shift right serial 0, then shift left serial 1
    write(8'h81);
    bus.SC_RegGENERAL_shiftselection_In = 2'b10;
    bus.SC_RegGENERAL_serial_In         = 1'b0;
    tick();
    check("shr_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h40);
    check("shr_carry", 32'(bus.SC_RegGENERAL_carry_Out),   32'd1);
    check("shr_lsb",   32'(bus.SC_RegGENERAL_lsb_Out),     32'd0);
    bus.SC_RegGENERAL_shiftselection_In = 2'b01;
    bus.SC_RegGENERAL_serial_In         = 1'b1;
    tick();
    check("shl_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h81);
    check("shl_carry", 32'(bus.SC_RegGENERAL_carry_Out),   32'd0);
    bus.SC_RegGENERAL_shiftselection_In = 2'b00;

    // 0x01 shifted right to zero
    write(8'h01);
    bus.SC_RegGENERAL_shiftselection_In = 2'b10;
    bus.SC_RegGENERAL_serial_In         = 1'b0;
    tick();
    check("shz_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h00);
    check("shz_zero",  32'(bus.SC_RegGENERAL_zero_Out),    32'd1);
    check("shz_carry", 32'(bus.SC_RegGENERAL_carry_Out),   32'd1);

    // Hold code 11 keeps register and carry
    bus.SC_RegGENERAL_shiftselection_In = 2'b11;
    bus.SC_RegGENERAL_serial_In         = 1'b1;
    tick();
    check("hold_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h00);
    check("hold_carry", 32'(bus.SC_RegGENERAL_carry_Out),   32'd1);

    // Shift in the capture cycle is dropped; shift in ACK executes
    bus.SC_RegGENERAL_shiftselection_In = 2'b01;
    bus.SC_RegGENERAL_serial_In         = 1'b1;
    bus.SC_RegGENERAL_wrreq_In          = 1'b1;
    bus.SC_RegGENERAL_data_InBUS        = 8'hA5;
    tick();
    check("cap_drop_shift", 32'(bus.SC_RegGENERAL_data_OutBUS), 32'hA5);
    tick();
    check("ack_shift_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h4B);
    check("ack_shift_carry", 32'(bus.SC_RegGENERAL_carry_Out),   32'd1);
    bus.SC_RegGENERAL_shiftselection_In = 2'b00;
    bus.SC_RegGENERAL_wrreq_In          = 1'b0;
    tick();
    tick();

    // Clear wins over a write in IDLE; write taken after clear releases
    bus.SC_RegGENERAL_clear_InLow = 1'b0;
    bus.SC_RegGENERAL_wrreq_In    = 1'b1;
    bus.SC_RegGENERAL_data_InBUS  = 8'h55;
    tick();
    check("clr_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'(INIT));
    check("clr_carry", 32'(bus.SC_RegGENERAL_carry_Out),   32'd0);
    check("clr_wrack", 32'(bus.SC_RegGENERAL_wrack_Out),   32'd0);
    bus.SC_RegGENERAL_clear_InLow = 1'b1;
    tick();
    check("clr_cap_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'h55);
    check("clr_cap_wrack", 32'(bus.SC_RegGENERAL_wrack_Out),   32'd0);
    tick();
    check("clr_ack", 32'(bus.SC_RegGENERAL_wrack_Out), 32'd1);
    bus.SC_RegGENERAL_wrreq_In = 1'b0;
    tick();
    tick();

    // Reset during ACK with wrreq still high aborts, then re-captures
    bus.SC_RegGENERAL_wrreq_In   = 1'b1;
    bus.SC_RegGENERAL_data_InBUS = 8'h33;
    tick();
    rst = 1'b1;
    check("rstack_wrack_pre", 32'(bus.SC_RegGENERAL_wrack_Out), 32'd0);
    tick();
    check("rstack_wrack", 32'(bus.SC_RegGENERAL_wrack_Out),   32'd0);
    check("rstack_data",  32'(bus.SC_RegGENERAL_data_OutBUS), 32'(INIT));
    rst = 1'b0;
    tick();
    check("rstack_recap", 32'(bus.SC_RegGENERAL_data_OutBUS), 32'h33);
    check("rstack_nack0", 32'(bus.SC_RegGENERAL_wrack_Out),   32'd0);
    tick();
    check("rstack_ack",   32'(bus.SC_RegGENERAL_wrack_Out),   32'd1);
    bus.SC_RegGENERAL_wrreq_In = 1'b0;
    tick();
    tick();

    // Random traffic against the model; data held stable while wrreq is high
    rnd_data = '0;
    for (int i = 0; i < 400; i++) begin
      bus.SC_RegGENERAL_shiftselection_In = 2'($urandom_range(0, 3));
      bus.SC_RegGENERAL_serial_In         = 1'($urandom_range(0, 1));
      bus.SC_RegGENERAL_clear_InLow       = ($urandom_range(0, 11) != 0);
      rst                                 = ($urandom_range(0, 59) == 0);
      if (!bus.SC_RegGENERAL_wrreq_In) begin
        rnd_data = W'($urandom);
        bus.SC_RegGENERAL_data_InBUS = rnd_data;
        bus.SC_RegGENERAL_wrreq_In   = ($urandom_range(0, 3) == 0);
      end else if (bus.SC_RegGENERAL_wrack_Out || $urandom_range(0, 7) == 0) begin
        bus.SC_RegGENERAL_wrreq_In = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
